hawk_pixel_axis_packer: RTL

- Downstream stage of the camera capture controller; consumes its two-pixels-per-beat stream (data_in/data_vld/data_end/frame_rst) and feeds the S2MM DMA AXI4-Stream slave.
- Packs two 24-bit beats (4 x 12-bit pixels) into one 64-bit word, each pixel zero-extended to 16 bits.
- Buffers words in a FIFO, since the pixel source has no backpressure.
- Marks the final word of each capture with tlast; reports drops via a sticky overflow flag.

---
 rtl/hawk_pixel_axis_packer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hawk_pixel_axis_packer.sv
// rtl/hawk_pixel_axis_packer.sv - packs 2-pixel capture beats into 64-bit AXI4-Stream words via a FWFT FIFO.
// Optional macro HAWK_PACKER_STATS_EN enables word_count/drop_count; otherwise they are tied to 0.
module hawk_pixel_axis_packer #(
  parameter int FIFO_DEPTH = 512,
  parameter int PIX_W      = 12
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          frame_rst,
  input  logic [2*PIX_W-1:0]            data_in,
  input  logic                          data_vld,
  input  logic                          data_end,
  output logic [63:0]                   m_axis_tdata,
  output logic [7:0]                    m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   word_count,
  output logic [15:0]                   drop_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PAD_W = 16 - PIX_W;
  localparam int EW    = 73;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_TAIL, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  half_q, half_d;
  logic [2*PIX_W-1:0]    part_q, part_d;
  logic                  stg_vld_q, stg_vld_d;
  logic [63:0]           stg_q, stg_d;
  logic                  end_q;
  logic                  end_rise;
  logic                  push;
  logic [EW-1:0]         push_word;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           mem_cnt_q;
  logic                  out_vld_q;
  logic [EW-1:0]         out_q;
  logic                  ovf_q;
  logic                  pop, full, wr_en, drop, ld;

  function automatic logic [31:0] lanes(input logic [2*PIX_W-1:0] d);
    return {{PAD_W{1'b0}}, d[2*PIX_W-1:PIX_W], {PAD_W{1'b0}}, d[PIX_W-1:0]};
  endfunction

  assign end_rise = data_end & ~end_q & (state_q == S_RUN);

  // A beat arriving with the end edge is absorbed in S_RUN; the flush runs from the next cycle.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    part_d    = part_q;
    stg_vld_d = stg_vld_q;
    stg_d     = stg_q;
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      S_RUN: begin
        if (data_vld) begin
          if (!half_q) begin
            half_d = 1'b1;
            part_d = data_in;
          end else begin
            half_d    = 1'b0;
            stg_d     = {lanes(data_in), lanes(part_q)};
            stg_vld_d = 1'b1;
            if (stg_vld_q) begin
              push      = 1'b1;
              push_word = {1'b0, 8'hFF, stg_q};
            end
          end
        end
        if (end_rise) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (half_q) begin
          if (stg_vld_q) begin
            push      = 1'b1;
            push_word = {1'b0, 8'hFF, stg_q};
            stg_vld_d = 1'b0;
            state_d   = S_TAIL;
          end else begin
            push      = 1'b1;
            push_word = {1'b1, 8'h0F, 32'h0, lanes(part_q)};
            half_d    = 1'b0;
            state_d   = S_DONE;
          end
        end else begin
          if (stg_vld_q) begin
            push      = 1'b1;
            push_word = {1'b1, 8'hFF, stg_q};
          end
          stg_vld_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_TAIL: begin
        push      = 1'b1;
        push_word = {1'b1, 8'h0F, 32'h0, lanes(part_q)};
        half_d    = 1'b0;
        state_d   = S_DONE;
      end
      default: ;
    endcase
    if (frame_rst) begin
      state_d   = S_RUN;
      half_d    = 1'b0;
      stg_vld_d = 1'b0;
      push      = 1'b0;
    end
  end

  assign pop   = out_vld_q & m_axis_tready;
  assign full  = out_vld_q & (mem_cnt_q == (AW+1)'(FIFO_DEPTH - 1));
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;
  assign ld    = (mem_cnt_q != '0) & (~out_vld_q | pop);

  // Storage never holds more than FIFO_DEPTH-1 entries, so a write cannot hit the slot being read.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_RUN;
      half_q    <= 1'b0;
      part_q    <= '0;
      stg_vld_q <= 1'b0;
      stg_q     <= '0;
      end_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      part_q    <= part_d;
      stg_vld_q <= stg_vld_d;
      stg_q     <= stg_d;
      end_q     <= data_end;
      if (frame_rst) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        mem_cnt_q <= '0;
        out_vld_q <= 1'b0;
        out_q     <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (ld) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          out_q    <= mem[rd_ptr_q];
        end
        out_vld_q <= ld | (out_vld_q & ~pop);
        mem_cnt_q <= mem_cnt_q + (AW+1)'(wr_en) - (AW+1)'(ld);
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  assign m_axis_tdata  = out_q[63:0];
  assign m_axis_tkeep  = out_q[71:64];
  assign m_axis_tlast  = out_q[72];
  assign m_axis_tvalid = out_vld_q;
  assign overflow      = ovf_q;
  assign fifo_level    = mem_cnt_q + (AW+1)'(out_vld_q);

`ifdef HAWK_PACKER_STATS_EN
  logic [31:0] wcnt_q;
  logic [15:0] dcnt_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wcnt_q <= '0;
      dcnt_q <= '0;
    end else if (frame_rst) begin
      wcnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      if (pop) wcnt_q <= wcnt_q + 32'd1;
      if (drop && dcnt_q != 16'hFFFF) dcnt_q <= dcnt_q + 16'd1;
    end
  end

  assign word_count = wcnt_q;
  assign drop_count = dcnt_q;
`else
  assign word_count = '0;
  assign drop_count = '0;
`endif

endmodule
